// File: rtl/wddl_xor_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : wddl_xor_tree_pipe
// Purpose  : Pipelined N-input WDDL dual-rail XOR tree. Each tree level is
//            registered, so a result appears LEVELS cycles after its operands
//            are accepted. An internal precharge/evaluate phase toggles every
//            cycle. Operands are accepted only in EVAL. Registered outputs are
//            checked every cycle for dual-rail integrity.
// Ports    : clk, rst            - clock and synchronous active-high reset
//            in_valid / in_ready - input handshake (in_ready = EVAL phase)
//            d_p_in / d_n_in     - N_IN packed operands, true/false rails
//            out_valid           - output holds a result token
//            d_p_out / d_n_out   - XOR of all operands, true/false rails
//            err_clr             - clears err and err_cnt
//            err / err_cnt       - sticky violation flag, saturating count
// Revision : 1.0  initial release
// ============================================================================
module wddl_xor_tree_pipe #(
    parameter int WIDTH = 1,
    parameter int N_IN  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN*WIDTH-1:0] d_p_in,
    input  logic [N_IN*WIDTH-1:0] d_n_in,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      d_p_out,
    output logic [WIDTH-1:0]      d_n_out,
    input  logic                  err_clr,
    output logic                  err,
    output logic [7:0]            err_cnt
);

    localparam int LEVELS = $clog2(N_IN);

    // Number of tree nodes at level k (level 0 = the operands themselves).
    function automatic int nodes_at(input int k);
        return (N_IN + (1 << k) - 1) >> k;
    endfunction

    // Index of the first node of level k in the flattened node list.
    function automatic int base_of(input int k);
        int s;
        s = 0;
        for (int j = 0; j < k; j++) begin
            s = s + nodes_at(j);
        end
        return s;
    endfunction

    localparam int TOTAL = base_of(LEVELS + 1);
    localparam int NREG  = TOTAL - N_IN;

    if (N_IN < 2 || N_IN > 16) begin : g_bad_n_in
        $error("wddl_xor_tree_pipe: N_IN must lie in 2..16");
    end

    logic                   r_ph;
    logic [LEVELS-1:0]      r_vld;
    logic [NREG*WIDTH-1:0]  r_p;
    logic [NREG*WIDTH-1:0]  r_n;
    logic [NREG*WIDTH-1:0]  w_nxt_p;
    logic [NREG*WIDTH-1:0]  w_nxt_n;
    logic [N_IN*WIDTH-1:0]  w_l0_p;
    logic [N_IN*WIDTH-1:0]  w_l0_n;
    logic [TOTAL*WIDTH-1:0] w_all_p;
    logic [TOTAL*WIDTH-1:0] w_all_n;
    logic                   w_xfer;
    logic                   w_viol;
    logic                   r_err;
    logic [7:0]             r_cnt;

    assign w_xfer = in_valid & r_ph;

    // Outside a transfer, level 0 is forced to spacer so that tokens and
    // spacers alternate through every stage.
    assign w_l0_p = w_xfer ? d_p_in : {(N_IN*WIDTH){1'b0}};
    assign w_l0_n = w_xfer ? d_n_in : {(N_IN*WIDTH){1'b0}};

    // All tree nodes in one flat list: level 0 first, then registered levels.
    assign w_all_p = {r_p, w_l0_p};
    assign w_all_n = {r_n, w_l0_n};

    genvar k, i;
    for (k = 1; k <= LEVELS; k = k + 1) begin : g_lvl
        localparam int SRC   = base_of(k - 1);
        localparam int SRC_N = nodes_at(k - 1);
        localparam int DST   = base_of(k) - N_IN;
        for (i = 0; i < nodes_at(k); i = i + 1) begin : g_node
            localparam int A = (SRC + 2 * i) * WIDTH;
            localparam int D = (DST + i) * WIDTH;
            if (2 * i + 1 < SRC_N) begin : g_pair
                localparam int B = A + WIDTH;
                // Positive-rail AND/OR only: spacer in gives spacer out.
                assign w_nxt_p[D +: WIDTH] = (w_all_p[A +: WIDTH] & w_all_n[B +: WIDTH])
                                           | (w_all_n[A +: WIDTH] & w_all_p[B +: WIDTH]);
                assign w_nxt_n[D +: WIDTH] = (w_all_p[A +: WIDTH] & w_all_p[B +: WIDTH])
                                           | (w_all_n[A +: WIDTH] & w_all_n[B +: WIDTH]);
            end else begin : g_pass
                // Odd leftover node is carried forward to keep equal latency.
                assign w_nxt_p[D +: WIDTH] = w_all_p[A +: WIDTH];
                assign w_nxt_n[D +: WIDTH] = w_all_n[A +: WIDTH];
            end
        end
    end

    // The last node of the last level is the top WIDTH bits of the registers.
    assign d_p_out   = r_p[NREG*WIDTH-1 -: WIDTH];
    assign d_n_out   = r_n[NREG*WIDTH-1 -: WIDTH];
    assign out_valid = r_vld[LEVELS-1];
    assign in_ready  = r_ph;
    assign err       = r_err;
    assign err_cnt   = r_cnt;

    // A token must have p != n on every bit; a spacer must be all zero.
    assign w_viol = out_valid ? (|(~(d_p_out ^ d_n_out))) : (|(d_p_out | d_n_out));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ph  <= 1'b0;
            r_vld <= '0;
            r_p   <= '0;
            r_n   <= '0;
            r_err <= 1'b0;
            r_cnt <= 8'd0;
        end else begin
            r_ph  <= ~r_ph;
            r_vld <= LEVELS'({r_vld, w_xfer});
            r_p   <= w_nxt_p;
            r_n   <= w_nxt_n;
            if (err_clr) begin
                r_err <= 1'b0;
                r_cnt <= 8'd0;
            end else if (w_viol) begin
                r_err <= 1'b1;
                if (r_cnt != 8'hFF) begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire
